// File: rtl/pipe_control_unit.sv
// pipe_control_unit: ID-stage decode, load-use / redirect hazard control and
// the ID->EX->MEM->WB control pipeline with saturating stall/flush counters.
module pipe_control_unit #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned CNT_W        = 16,
  parameter bit          ENABLE_ITYPE = 1'b1,
  parameter bit          JUMP_WB      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_redirect,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              ex_alu_src,
  output logic              ex_jal,
  output logic              ex_jalr,
  output logic              ex_illegal,
  output logic [1:0]        ex_alu_op,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_branch,
  output logic              mem_read,
  output logic              mem_write,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned OP_W  = 5;
  localparam int unsigned AOP_W = 2;

  localparam logic [OP_W-1:0] OP_LOAD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_STORE  = 5'b00010;
  localparam logic [OP_W-1:0] OP_RTYPE  = 5'b00011;
  localparam logic [OP_W-1:0] OP_BRANCH = 5'b00110;
  localparam logic [OP_W-1:0] OP_ITYPE  = 5'b00100;
  localparam logic [OP_W-1:0] OP_JAL    = 5'b11011;
  localparam logic [OP_W-1:0] OP_JALR   = 5'b11001;

  // Decode results (ID stage)
  logic              dec_alu_src;
  logic              dec_jal;
  logic              dec_jalr;
  logic              dec_illegal;
  logic [AOP_W-1:0]  dec_alu_op;
  logic              dec_branch;
  logic              dec_mem_read;
  logic              dec_mem_write;
  logic              dec_reg_write;
  logic              dec_mem_to_reg;
  logic [REG_AW-1:0] dec_rd;
  logic              dec_uses_rs2;

  // Hazard control
  logic              load_use_c;
  logic              ex_bubble_c;
  logic              stall_inc_c;

  // ID->EX register
  logic              ex_alu_src_q,   ex_alu_src_d;
  logic              ex_jal_q,       ex_jal_d;
  logic              ex_jalr_q,      ex_jalr_d;
  logic              ex_illegal_q,   ex_illegal_d;
  logic [AOP_W-1:0]  ex_alu_op_q,    ex_alu_op_d;
  logic              ex_branch_q,    ex_branch_d;
  logic              ex_mem_read_q,  ex_mem_read_d;
  logic              ex_mem_write_q, ex_mem_write_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_to_reg_q, ex_mem_to_reg_d;
  logic [REG_AW-1:0] ex_rd_q,        ex_rd_d;

  // EX->MEM register
  logic              mem_branch_q,     mem_branch_d;
  logic              mem_read_q,       mem_read_d;
  logic              mem_write_q,      mem_write_d;
  logic              mem_reg_write_q,  mem_reg_write_d;
  logic              mem_mem_to_reg_q, mem_mem_to_reg_d;
  logic [REG_AW-1:0] mem_rd_q,         mem_rd_d;

  // MEM->WB register
  logic              wb_reg_write_q,  wb_reg_write_d;
  logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [REG_AW-1:0] wb_rd_q,         wb_rd_d;

  // Performance counters
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  // Opcode decode; an invalid ID slot decodes to a clean bubble
  always_comb begin
    dec_alu_src    = 1'b0;
    dec_jal        = 1'b0;
    dec_jalr       = 1'b0;
    dec_illegal    = 1'b0;
    dec_alu_op     = 2'b00;
    dec_branch     = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_rd         = '0;
    if (id_valid) begin
      dec_rd = id_rd;
      case (id_opcode)
        OP_LOAD: begin
          dec_mem_read   = 1'b1;
          dec_mem_to_reg = 1'b1;
          dec_alu_src    = 1'b1;
          dec_reg_write  = 1'b1;
        end
        OP_STORE: begin
          dec_mem_write = 1'b1;
          dec_alu_src   = 1'b1;
        end
        OP_RTYPE: begin
          dec_reg_write = 1'b1;
          dec_alu_op    = 2'b10;
        end
        OP_BRANCH: begin
          dec_branch = 1'b1;
          dec_alu_op = 2'b01;
        end
        OP_ITYPE: begin
          if (ENABLE_ITYPE) begin
            dec_alu_src   = 1'b1;
            dec_reg_write = 1'b1;
            dec_alu_op    = 2'b11;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        OP_JAL: begin
          dec_jal       = 1'b1;
          dec_reg_write = JUMP_WB;
        end
        OP_JALR: begin
          dec_jalr      = 1'b1;
          dec_alu_src   = 1'b1;
          dec_reg_write = JUMP_WB;
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  // Instructions that read rs2 (hazard relevance only)
  always_comb begin
    dec_uses_rs2 = 1'b0;
    if ((id_opcode == OP_STORE) || (id_opcode == OP_RTYPE) || (id_opcode == OP_BRANCH)) begin
      dec_uses_rs2 = 1'b1;
    end
  end

  // Load in EX feeding a source of the instruction in ID; x0 never hazards
  always_comb begin
    load_use_c = 1'b0;
    if (id_valid && ex_mem_read_q && (ex_rd_q != '0)) begin
      if ((ex_rd_q == id_rs1) || (dec_uses_rs2 && (ex_rd_q == id_rs2))) begin
        load_use_c = 1'b1;
      end
    end
  end

  // Front-end steering: reset > redirect > load-use stall > normal advance
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    ex_bubble_c = 1'b0;
    stall_inc_c = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      ex_bubble_c = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush  = 1'b1;
      ex_bubble_c = 1'b1;
    end else if (load_use_c) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ex_bubble_c = 1'b1;
      stall_inc_c = 1'b1;
    end
  end

  // Pipeline next-state: ID->EX takes decode or a bubble, later stages just shift
  always_comb begin
    ex_alu_src_d    = ex_bubble_c ? 1'b0 : dec_alu_src;
    ex_jal_d        = ex_bubble_c ? 1'b0 : dec_jal;
    ex_jalr_d       = ex_bubble_c ? 1'b0 : dec_jalr;
    ex_illegal_d    = ex_bubble_c ? 1'b0 : dec_illegal;
    ex_alu_op_d     = ex_bubble_c ? 2'b00 : dec_alu_op;
    ex_branch_d     = ex_bubble_c ? 1'b0 : dec_branch;
    ex_mem_read_d   = ex_bubble_c ? 1'b0 : dec_mem_read;
    ex_mem_write_d  = ex_bubble_c ? 1'b0 : dec_mem_write;
    ex_reg_write_d  = ex_bubble_c ? 1'b0 : dec_reg_write;
    ex_mem_to_reg_d = ex_bubble_c ? 1'b0 : dec_mem_to_reg;
    ex_rd_d         = ex_bubble_c ? '0 : dec_rd;

    mem_branch_d     = ex_branch_q;
    mem_read_d       = ex_mem_read_q;
    mem_write_d      = ex_mem_write_q;
    mem_reg_write_d  = ex_reg_write_q;
    mem_mem_to_reg_d = ex_mem_to_reg_q;
    mem_rd_d         = ex_rd_q;

    wb_reg_write_d  = mem_reg_write_q;
    wb_mem_to_reg_d = mem_mem_to_reg_q;
    wb_rd_d         = mem_rd_q;
  end

  // Saturating counter next-state
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (!rst && ex_redirect && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Control pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_alu_src_q     <= 1'b0;
      ex_jal_q         <= 1'b0;
      ex_jalr_q        <= 1'b0;
      ex_illegal_q     <= 1'b0;
      ex_alu_op_q      <= 2'b00;
      ex_branch_q      <= 1'b0;
      ex_mem_read_q    <= 1'b0;
      ex_mem_write_q   <= 1'b0;
      ex_reg_write_q   <= 1'b0;
      ex_mem_to_reg_q  <= 1'b0;
      ex_rd_q          <= '0;
      mem_branch_q     <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      mem_rd_q         <= '0;
      wb_reg_write_q   <= 1'b0;
      wb_mem_to_reg_q  <= 1'b0;
      wb_rd_q          <= '0;
    end else begin
      ex_alu_src_q     <= ex_alu_src_d;
      ex_jal_q         <= ex_jal_d;
      ex_jalr_q        <= ex_jalr_d;
      ex_illegal_q     <= ex_illegal_d;
      ex_alu_op_q      <= ex_alu_op_d;
      ex_branch_q      <= ex_branch_d;
      ex_mem_read_q    <= ex_mem_read_d;
      ex_mem_write_q   <= ex_mem_write_d;
      ex_reg_write_q   <= ex_reg_write_d;
      ex_mem_to_reg_q  <= ex_mem_to_reg_d;
      ex_rd_q          <= ex_rd_d;
      mem_branch_q     <= mem_branch_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_to_reg_q <= mem_mem_to_reg_d;
      mem_rd_q         <= mem_rd_d;
      wb_reg_write_q   <= wb_reg_write_d;
      wb_mem_to_reg_q  <= wb_mem_to_reg_d;
      wb_rd_q          <= wb_rd_d;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_alu_src    = ex_alu_src_q;
  assign ex_jal        = ex_jal_q;
  assign ex_jalr       = ex_jalr_q;
  assign ex_illegal    = ex_illegal_q;
  assign ex_alu_op     = ex_alu_op_q;
  assign ex_rd         = ex_rd_q;
  assign mem_branch    = mem_branch_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_rd        = mem_rd_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_rd         = wb_rd_q;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: two DUT configurations driven in lockstep; a queue-based
// reference pipeline predicts every output and a negedge monitor checks them.
module tb_pipe_control_unit;

  localparam int NCFG = 2;

  typedef struct packed {
    logic       alu_src;
    logic       jal;
    logic       jalr;
    logic       illegal;
    logic [1:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } ctrl_t;

  typedef struct {
    int    cfg;
    bit    regs_known;
    logic  pc_write;
    logic  ifid_write;
    logic  ifid_flush;
    ctrl_t ex;
    ctrl_t mem;
    ctrl_t wb;
    int    stall;
    int    flush;
  } exp_t;

  localparam logic [4:0] LOAD = 5'b00000, STORE = 5'b00010, RTYPE = 5'b00011,
                         BRANCH = 5'b00110, ITYPE = 5'b00100, JAL = 5'b11011, JALR = 5'b11001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_opcode = '0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic [4:0] id_rd = '0;
  logic       ex_redirect = 1'b0;

  logic       o_pc_write[NCFG], o_ifid_write[NCFG], o_ifid_flush[NCFG];
  logic       o_ex_alu_src[NCFG], o_ex_jal[NCFG], o_ex_jalr[NCFG], o_ex_illegal[NCFG];
  logic [1:0] o_ex_alu_op[NCFG];
  logic [4:0] o_ex_rd[NCFG], o_mem_rd[NCFG], o_wb_rd[NCFG];
  logic       o_mem_branch[NCFG], o_mem_read[NCFG], o_mem_write[NCFG];
  logic       o_wb_reg_write[NCFG], o_wb_mem_to_reg[NCFG];
  logic [15:0] o_stall0, o_flush0;
  logic [3:0]  o_stall1, o_flush1;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  // Reference model state: index 0 = EX, 1 = MEM, 2 = WB
  ctrl_t pipe_m[NCFG][3];
  int    m_stall[NCFG];
  int    m_flush[NCFG];
  bit    known = 1'b0;
  int    cnt_max[NCFG] = '{65535, 15};
  bit    itype_en[NCFG] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  pipe_control_unit #(.REG_AW(5), .CNT_W(16), .ENABLE_ITYPE(1'b1), .JUMP_WB(1'b1)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
    .pc_write(o_pc_write[0]), .ifid_write(o_ifid_write[0]), .ifid_flush(o_ifid_flush[0]),
    .ex_alu_src(o_ex_alu_src[0]), .ex_jal(o_ex_jal[0]), .ex_jalr(o_ex_jalr[0]),
    .ex_illegal(o_ex_illegal[0]), .ex_alu_op(o_ex_alu_op[0]), .ex_rd(o_ex_rd[0]),
    .mem_branch(o_mem_branch[0]), .mem_read(o_mem_read[0]), .mem_write(o_mem_write[0]),
    .mem_rd(o_mem_rd[0]), .wb_reg_write(o_wb_reg_write[0]), .wb_mem_to_reg(o_wb_mem_to_reg[0]),
    .wb_rd(o_wb_rd[0]), .stall_cnt(o_stall0), .flush_cnt(o_flush0)
  );

  pipe_control_unit #(.REG_AW(5), .CNT_W(4), .ENABLE_ITYPE(1'b0), .JUMP_WB(1'b1)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
    .pc_write(o_pc_write[1]), .ifid_write(o_ifid_write[1]), .ifid_flush(o_ifid_flush[1]),
    .ex_alu_src(o_ex_alu_src[1]), .ex_jal(o_ex_jal[1]), .ex_jalr(o_ex_jalr[1]),
    .ex_illegal(o_ex_illegal[1]), .ex_alu_op(o_ex_alu_op[1]), .ex_rd(o_ex_rd[1]),
    .mem_branch(o_mem_branch[1]), .mem_read(o_mem_read[1]), .mem_write(o_mem_write[1]),
    .mem_rd(o_mem_rd[1]), .wb_reg_write(o_wb_reg_write[1]), .wb_mem_to_reg(o_wb_mem_to_reg[1]),
    .wb_rd(o_wb_rd[1]), .stall_cnt(o_stall1), .flush_cnt(o_flush1)
  );

  function automatic void chk(string name, int cfg, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d @%0t: got %h expected %h", name, cfg, $time, act, exp);
    end
  endfunction

  // Spec decode table, expressed as the set of controls each opcode turns on
  function automatic ctrl_t ref_decode(bit v, logic [4:0] op, logic [4:0] rd, bit it_en);
    ctrl_t c = '0;
    if (!v) return c;
    c.rd = rd;
    if (op == LOAD) begin
      c.mem_read = 1; c.mem_to_reg = 1; c.alu_src = 1; c.reg_write = 1;
    end else if (op == STORE) begin
      c.mem_write = 1; c.alu_src = 1;
    end else if (op == RTYPE) begin
      c.reg_write = 1; c.alu_op = 2'b10;
    end else if (op == BRANCH) begin
      c.branch = 1; c.alu_op = 2'b01;
    end else if (op == ITYPE && it_en) begin
      c.alu_src = 1; c.reg_write = 1; c.alu_op = 2'b11;
    end else if (op == JAL) begin
      c.jal = 1; c.reg_write = 1;
    end else if (op == JALR) begin
      c.jalr = 1; c.alu_src = 1; c.reg_write = 1;
    end else begin
      c.illegal = 1;
    end
    return c;
  endfunction

  // One cycle: drive inputs, predict this cycle's outputs, advance the model
  task automatic step(input bit r, input bit v, input logic [4:0] op, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input bit redir);
    rst = r; id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    ex_redirect = redir;
    for (int c = 0; c < NCFG; c++) begin
      exp_t e;
      bit   lu;
      bit   uses2;
      uses2 = (op == STORE) || (op == RTYPE) || (op == BRANCH);
      lu = v && pipe_m[c][0].mem_read && (pipe_m[c][0].rd != 0) &&
           ((pipe_m[c][0].rd == rs1) || (uses2 && (pipe_m[c][0].rd == rs2)));
      e.cfg = c; e.regs_known = known;
      e.ex = pipe_m[c][0]; e.mem = pipe_m[c][1]; e.wb = pipe_m[c][2];
      e.stall = m_stall[c]; e.flush = m_flush[c];
      if (r)          begin e.pc_write = 0; e.ifid_write = 0; e.ifid_flush = 1; end
      else if (redir) begin e.pc_write = 1; e.ifid_write = 1; e.ifid_flush = 1; end
      else if (lu)    begin e.pc_write = 0; e.ifid_write = 0; e.ifid_flush = 0; end
      else            begin e.pc_write = 1; e.ifid_write = 1; e.ifid_flush = 0; end
      exp_q.push_back(e);
      if (r) begin
        for (int s = 0; s < 3; s++) pipe_m[c][s] = '0;
        m_stall[c] = 0; m_flush[c] = 0;
      end else begin
        pipe_m[c][2] = pipe_m[c][1];
        pipe_m[c][1] = pipe_m[c][0];
        pipe_m[c][0] = (redir || lu) ? ctrl_t'('0) : ref_decode(v, op, rd, itype_en[c]);
        if (lu && !redir) m_stall[c] = (m_stall[c] + 1 > cnt_max[c]) ? cnt_max[c] : m_stall[c] + 1;
        if (redir)        m_flush[c] = (m_flush[c] + 1 > cnt_max[c]) ? cnt_max[c] : m_flush[c] + 1;
      end
    end
    if (r) known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    step(0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  // Monitor: compare every output the DUT presents against queued predictions
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        int   c;
        e = exp_q.pop_front();
        c = e.cfg;
        chk("pc_write", c, 32'(o_pc_write[c]), 32'(e.pc_write));
        chk("ifid_write", c, 32'(o_ifid_write[c]), 32'(e.ifid_write));
        chk("ifid_flush", c, 32'(o_ifid_flush[c]), 32'(e.ifid_flush));
        if (e.regs_known) begin
          chk("ex_stage", c,
              32'({o_ex_alu_src[c], o_ex_jal[c], o_ex_jalr[c], o_ex_illegal[c], o_ex_alu_op[c], o_ex_rd[c]}),
              32'({e.ex.alu_src, e.ex.jal, e.ex.jalr, e.ex.illegal, e.ex.alu_op, e.ex.rd}));
          chk("mem_stage", c,
              32'({o_mem_branch[c], o_mem_read[c], o_mem_write[c], o_mem_rd[c]}),
              32'({e.mem.branch, e.mem.mem_read, e.mem.mem_write, e.mem.rd}));
          chk("wb_stage", c,
              32'({o_wb_reg_write[c], o_wb_mem_to_reg[c], o_wb_rd[c]}),
              32'({e.wb.reg_write, e.wb.mem_to_reg, e.wb.rd}));
          chk("stall_cnt", c, (c == 0) ? 32'(o_stall0) : 32'(o_stall1), 32'(e.stall));
          chk("flush_cnt", c, (c == 0) ? 32'(o_flush0) : 32'(o_flush1), 32'(e.flush));
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [4:0] ops[8];
    ops = '{LOAD, STORE, RTYPE, BRANCH, ITYPE, JAL, JALR, LOAD};
    @(posedge clk);
    #1;
    step(1, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
    step(1, 1, LOAD, 5'd1, 5'd2, 5'd3, 1);
    nop();

    // Decode sweep over every opcode
    for (int i = 0; i < 32; i++) step(0, 1, 5'(i), 5'd0, 5'd0, 5'(i), 0);
    nop();

    // Load-use: stall one cycle, then the consumer advances
    step(0, 1, LOAD, 5'd1, 5'd0, 5'd5, 0);
    step(0, 1, RTYPE, 5'd1, 5'd5, 5'd7, 0);
    step(0, 1, RTYPE, 5'd1, 5'd5, 5'd7, 0);
    nop();

    // Redirect arriving in what would be the stall cycle
    step(0, 1, LOAD, 5'd2, 5'd0, 5'd6, 0);
    step(0, 1, RTYPE, 5'd6, 5'd1, 5'd8, 1);
    nop();

    // Load to x0 never stalls its consumer
    step(0, 1, LOAD, 5'd1, 5'd0, 5'd0, 0);
    step(0, 1, RTYPE, 5'd0, 5'd0, 5'd2, 0);
    nop();

    // Stall counter saturation on the 4-bit instance
    for (int i = 0; i < 18; i++) begin
      step(0, 1, LOAD, 5'd1, 5'd0, 5'd3, 0);
      step(0, 1, STORE, 5'd1, 5'd3, 5'd0, 0);
      step(0, 1, STORE, 5'd1, 5'd3, 5'd0, 0);
    end
    #3;
    chk("sat_stall", 1, 32'(o_stall1), 32'd15);

    // Flush counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) step(0, 1, RTYPE, 5'd1, 5'd2, 5'd3, 1);
    #3;
    chk("sat_flush", 1, 32'(o_flush1), 32'd15);
    nop();

    // Reset while a load sits in MEM
    step(0, 1, LOAD, 5'd1, 5'd0, 5'd4, 0);
    nop();
    step(1, 1, RTYPE, 5'd4, 5'd4, 5'd9, 1);
    #3;
    chk("rst_mem_read", 0, 32'(o_mem_read[0]), 32'd0);
    chk("rst_wb_reg_write", 0, 32'(o_wb_reg_write[0]), 32'd0);
    nop();

    // Reset in the middle of a load-use stall
    step(0, 1, LOAD, 5'd1, 5'd0, 5'd2, 0);
    step(1, 1, RTYPE, 5'd2, 5'd0, 5'd5, 0);
    step(0, 1, RTYPE, 5'd2, 5'd0, 5'd5, 0);
    nop();

    // Randomized traffic with a narrow register range to provoke hazards
    for (int i = 0; i < 600; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 7)];
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), op,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0));
    end
    nop();

    @(negedge clk);
    #1;
    chk("queue_drain", 0, 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
